// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - bundled fetch-address, imem and decode handshakes for instr_fetch
// Optional macro: FETCH_MISALIGN_CHECK_EN adds if_misalign.
// Signals:
//   pc_valid/pc_in/pc_ready             : fetch address from the program counter
//   imem_req/imem_addr/imem_gnt         : instruction-memory request channel
//   imem_rvalid/imem_rdata              : in-order instruction-memory response channel
//   if_valid/if_pc/if_instr/if_ready    : fetched instruction towards decode
//   flush                               : discard everything fetched or in flight
// Modports: master = fetch unit, slave = surrounding core / memory.
interface instr_fetch_if;
  logic        pc_valid;
  logic [31:0] pc_in;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        flush;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        if_misalign;

  modport master (
    input  pc_valid, pc_in, imem_gnt, imem_rvalid, imem_rdata, if_ready, flush,
    output pc_ready, imem_req, imem_addr, if_valid, if_pc, if_instr, if_misalign
  );

  modport slave (
    output pc_valid, pc_in, imem_gnt, imem_rvalid, imem_rdata, if_ready, flush,
    input  pc_ready, imem_req, imem_addr, if_valid, if_pc, if_instr, if_misalign
  );
`else
  modport master (
    input  pc_valid, pc_in, imem_gnt, imem_rvalid, imem_rdata, if_ready, flush,
    output pc_ready, imem_req, imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output pc_valid, pc_in, imem_gnt, imem_rvalid, imem_rdata, if_ready, flush,
    input  pc_ready, imem_req, imem_addr, if_valid, if_pc, if_instr
  );
`endif
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with bounded outstanding requests and output FIFO
// Optional macro: FETCH_MISALIGN_CHECK_EN (misaligned PCs become NOP entries flagged if_misalign).
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : instr_fetch_if.master (pc handshake, imem request/response, decode handshake, flush)
// Parameter FIFO_DEPTH: fetch slots (outstanding + buffered), power of 2, >= 2.
module instr_fetch #(
  parameter int FIFO_DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] fifo_cnt_q;
  logic [CW-1:0] occ;
  logic [CW-1:0] inflight;
  logic [AW-1:0] pcq_wr_q, pcq_rd_q;
  logic [AW-1:0] fifo_wr_q, fifo_rd_q;
  logic [31:0]   pcq_mem        [FIFO_DEPTH];
  logic [31:0]   fifo_pc_mem    [FIFO_DEPTH];
  logic [31:0]   fifo_instr_mem [FIFO_DEPTH];

  logic        credit;
  logic        run_ok;
  logic        accept;
  logic        rsp_hit;
  logic        rsp_any;
  logic        fifo_push;
  logic        fifo_pop;
  logic [31:0] push_pc;
  logic [31:0] push_instr;

  assign occ      = outstanding_q + fifo_cnt_q;
  assign inflight = outstanding_q + drop_q;
  assign credit   = occ < DEPTH_C;
  // rst_n gating keeps the request side quiet while reset is held.
  assign run_ok   = rst_n && (state_q == RUN) && !bus.flush;

  assign bus.imem_addr = {bus.pc_in[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  logic misaligned;
  logic trap_ready;
  logic trap_accept;
  logic fifo_mis_mem [FIFO_DEPTH];

  assign misaligned = bus.pc_in[1:0] != 2'b00;
  assign bus.imem_req = bus.pc_valid && credit && run_ok && !misaligned;
  // A trap entry bypasses memory, so it may only enter once every earlier
  // request has returned; otherwise it would overtake them in the FIFO.
  assign trap_ready  = credit && run_ok && (outstanding_q == '0);
  assign trap_accept = bus.pc_valid && misaligned && trap_ready;
  assign bus.pc_ready = misaligned ? trap_ready : (bus.imem_req && bus.imem_gnt);
  assign bus.if_misalign = bus.if_valid && fifo_mis_mem[fifo_rd_q];
`else
  assign bus.imem_req = bus.pc_valid && credit && run_ok;
  assign bus.pc_ready = bus.imem_req && bus.imem_gnt;
`endif

  assign accept = bus.imem_req && bus.imem_gnt;

  // Response with nothing outstanding is a protocol error and is ignored.
  assign rsp_any = bus.imem_rvalid && (inflight != '0);
  assign rsp_hit = bus.imem_rvalid && (state_q == RUN) && (outstanding_q != '0) && !bus.flush;

`ifdef FETCH_MISALIGN_CHECK_EN
  // rsp_hit needs outstanding != 0 and trap_accept needs it == 0: never both.
  assign fifo_push  = rsp_hit || trap_accept;
  assign push_pc    = rsp_hit ? pcq_mem[pcq_rd_q] : bus.pc_in;
  assign push_instr = rsp_hit ? bus.imem_rdata : NOP_INSTR;
`else
  assign fifo_push  = rsp_hit;
  assign push_pc    = pcq_mem[pcq_rd_q];
  assign push_instr = bus.imem_rdata;
`endif

  assign bus.if_valid = fifo_cnt_q != '0;
  assign bus.if_pc    = fifo_pc_mem[fifo_rd_q];
  assign bus.if_instr = fifo_instr_mem[fifo_rd_q];
  // Decode still sees the old head during a flush, but that handshake is void.
  assign fifo_pop     = bus.if_valid && bus.if_ready && !bus.flush;

  // Drain FSM: counts responses owed by memory for requests killed by a flush.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    if (bus.flush) begin
      // Everything still owed (live or already being dropped) minus a
      // response that lands in this very cycle.
      drop_d  = inflight - CW'(rsp_any);
      state_d = (drop_d != '0) ? DRAIN : RUN;
    end else if ((state_q == DRAIN) && bus.imem_rvalid) begin
      drop_d = drop_q - ONE_C;
      if (drop_q == ONE_C) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Outstanding requests and their PCs, returned in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
    end else if (bus.flush) begin
      outstanding_q <= '0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
    end else begin
      if (accept) begin
        pcq_wr_q <= pcq_wr_q + ONE_A;
      end
      if (rsp_hit) begin
        pcq_rd_q <= pcq_rd_q + ONE_A;
      end
      if (accept && !rsp_hit) begin
        outstanding_q <= outstanding_q + ONE_C;
      end else if (!accept && rsp_hit) begin
        outstanding_q <= outstanding_q - ONE_C;
      end
    end
  end

  // Output FIFO pointers and fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt_q <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
    end else if (bus.flush) begin
      fifo_cnt_q <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
    end else begin
      if (fifo_push) begin
        fifo_wr_q <= fifo_wr_q + ONE_A;
      end
      if (fifo_pop) begin
        fifo_rd_q <= fifo_rd_q + ONE_A;
      end
      if (fifo_push && !fifo_pop) begin
        fifo_cnt_q <= fifo_cnt_q + ONE_C;
      end else if (!fifo_push && fifo_pop) begin
        fifo_cnt_q <= fifo_cnt_q - ONE_C;
      end
    end
  end

  // Storage arrays carry no reset; validity comes from the pointers and counts.
  always_ff @(posedge clk) begin
    if (accept) begin
      pcq_mem[pcq_wr_q] <= bus.pc_in;
    end
    if (fifo_push) begin
      fifo_pc_mem[fifo_wr_q]    <= push_pc;
      fifo_instr_mem[fifo_wr_q] <= push_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
      fifo_mis_mem[fifo_wr_q]   <= !rsp_hit;
`endif
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed table-driven bench for instr_fetch
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch #(.FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        ifr;
    logic        fl;
    logic        e_req;
    logic        e_rdy;
    logic        e_ifv;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic pv, input logic [31:0] pc, input logic gnt,
                              input logic rv, input logic [31:0] rdata, input logic ifr,
                              input logic fl, input logic e_req, input logic e_rdy,
                              input logic e_ifv, input logic [31:0] e_pc,
                              input logic [31:0] e_instr);
    vec_t v;
    v.pv = pv; v.pc = pc; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.ifr = ifr; v.fl = fl;
    v.e_req = e_req; v.e_rdy = e_rdy; v.e_ifv = e_ifv; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setin(input logic pv, input logic [31:0] pc, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic ifr, input logic fl);
    bus.pc_valid    = pv;
    bus.pc_in       = pc;
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rdata;
    bus.if_ready    = ifr;
    bus.flush       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    setin(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_pc_ready", 32'(bus.pc_ready), 32'd0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_if_misalign", 32'(bus.if_misalign), 32'd0);
`endif
    rst_n = 1'b1;

    //            pv pc            gnt rv rdata          ifr fl  req rdy ifv e_pc          e_instr
    tv.push_back(mk(1, 32'h000, 1, 0, 32'h0,        1, 0,  1, 1, 0, 32'h0,   32'h0));
    tv.push_back(mk(1, 32'h004, 1, 1, 32'hA0000000, 1, 0,  1, 1, 0, 32'h0,   32'h0));
    tv.push_back(mk(1, 32'h008, 1, 1, 32'hA0000004, 1, 0,  0, 0, 1, 32'h000, 32'hA0000000));
    tv.push_back(mk(1, 32'h008, 1, 0, 32'h0,        1, 0,  1, 1, 1, 32'h004, 32'hA0000004));
    tv.push_back(mk(0, 32'h000, 0, 1, 32'hA0000008, 1, 0,  0, 0, 0, 32'h0,   32'h0));
    tv.push_back(mk(0, 32'h000, 0, 0, 32'h0,        1, 0,  0, 0, 1, 32'h008, 32'hA0000008));
    // decode stalled: two accepts fill both slots, then back-pressure until a pop
    tv.push_back(mk(1, 32'h100, 1, 0, 32'h0,        0, 0,  1, 1, 0, 32'h0,   32'h0));
    tv.push_back(mk(1, 32'h104, 1, 1, 32'hB0000000, 0, 0,  1, 1, 0, 32'h0,   32'h0));
    tv.push_back(mk(1, 32'h108, 1, 1, 32'hB0000004, 0, 0,  0, 0, 1, 32'h100, 32'hB0000000));
    tv.push_back(mk(1, 32'h108, 1, 0, 32'h0,        0, 0,  0, 0, 1, 32'h100, 32'hB0000000));
    tv.push_back(mk(1, 32'h108, 1, 0, 32'h0,        1, 0,  0, 0, 1, 32'h100, 32'hB0000000));
    tv.push_back(mk(1, 32'h108, 1, 0, 32'h0,        0, 0,  1, 1, 1, 32'h104, 32'hB0000004));
    // build two outstanding, flush, drain two 0xDEAD responses
    tv.push_back(mk(1, 32'h10C, 1, 0, 32'h0,        1, 0,  0, 0, 1, 32'h104, 32'hB0000004));
    tv.push_back(mk(1, 32'h10C, 1, 0, 32'h0,        1, 0,  1, 1, 0, 32'h0,   32'h0));
    tv.push_back(mk(1, 32'h110, 1, 0, 32'h0,        1, 0,  0, 0, 0, 32'h0,   32'h0));
    tv.push_back(mk(1, 32'h110, 1, 0, 32'h0,        1, 1,  0, 0, 0, 32'h0,   32'h0));
    tv.push_back(mk(1, 32'h110, 1, 1, 32'h0000DEAD, 1, 0,  0, 0, 0, 32'h0,   32'h0));
    tv.push_back(mk(1, 32'h110, 1, 1, 32'h0000DEAD, 1, 0,  0, 0, 0, 32'h0,   32'h0));
    tv.push_back(mk(1, 32'h200, 1, 0, 32'h0,        1, 0,  1, 1, 0, 32'h0,   32'h0));
    // flush coincides with one of two responses: exactly one more dropped
    tv.push_back(mk(1, 32'h204, 1, 0, 32'h0,        1, 0,  1, 1, 0, 32'h0,   32'h0));
    tv.push_back(mk(1, 32'h208, 1, 1, 32'hC0000000, 1, 1,  0, 0, 0, 32'h0,   32'h0));
    tv.push_back(mk(1, 32'h300, 1, 0, 32'h0,        1, 0,  0, 0, 0, 32'h0,   32'h0));
    tv.push_back(mk(1, 32'h300, 1, 1, 32'h0000DEAD, 1, 0,  0, 0, 0, 32'h0,   32'h0));
    tv.push_back(mk(1, 32'h300, 1, 0, 32'h0,        1, 0,  1, 1, 0, 32'h0,   32'h0));
    tv.push_back(mk(0, 32'h000, 0, 1, 32'hD0000300, 1, 0,  0, 0, 0, 32'h0,   32'h0));
    tv.push_back(mk(0, 32'h000, 0, 0, 32'h0,        1, 0,  0, 0, 1, 32'h300, 32'hD0000300));
    // flush while an entry is buffered: still visible in the flush cycle, gone after
    tv.push_back(mk(1, 32'h400, 1, 0, 32'h0,        0, 0,  1, 1, 0, 32'h0,   32'h0));
    tv.push_back(mk(0, 32'h000, 0, 1, 32'hE0000400, 0, 0,  0, 0, 0, 32'h0,   32'h0));
    tv.push_back(mk(0, 32'h000, 0, 0, 32'h0,        1, 1,  0, 0, 1, 32'h400, 32'hE0000400));
    tv.push_back(mk(1, 32'h500, 1, 0, 32'h0,        1, 0,  1, 1, 0, 32'h0,   32'h0));
    // spurious response with nothing outstanding must not underflow
    tv.push_back(mk(0, 32'h000, 0, 1, 32'hF0000500, 1, 0,  0, 0, 0, 32'h0,   32'h0));
    tv.push_back(mk(0, 32'h000, 0, 1, 32'hBAD00000, 1, 0,  0, 0, 1, 32'h500, 32'hF0000500));
    tv.push_back(mk(0, 32'h000, 0, 0, 32'h0,        1, 0,  0, 0, 0, 32'h0,   32'h0));
    tv.push_back(mk(1, 32'h600, 0, 0, 32'h0,        1, 0,  1, 0, 0, 32'h0,   32'h0));

    for (int i = 0; i < tv.size(); i++) begin
      setin(tv[i].pv, tv[i].pc, tv[i].gnt, tv[i].rv, tv[i].rdata, tv[i].ifr, tv[i].fl);
      #3;
      chk($sformatf("row%0d_imem_req", i), 32'(bus.imem_req), 32'(tv[i].e_req));
      chk($sformatf("row%0d_pc_ready", i), 32'(bus.pc_ready), 32'(tv[i].e_rdy));
      chk($sformatf("row%0d_if_valid", i), 32'(bus.if_valid), 32'(tv[i].e_ifv));
      if (tv[i].e_req)
        chk($sformatf("row%0d_imem_addr", i), bus.imem_addr, tv[i].pc & 32'hFFFF_FFFC);
      if (tv[i].e_ifv) begin
        chk($sformatf("row%0d_if_pc", i), bus.if_pc, tv[i].e_pc);
        chk($sformatf("row%0d_if_instr", i), bus.if_instr, tv[i].e_instr);
      end
      tick();
    end

    // low address bits: masked on the request (default) or trapped (misalign build)
    setin(1'b1, 32'h103, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    #3;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis103_imem_req", 32'(bus.imem_req), 32'd0);
    chk("mis103_pc_ready", 32'(bus.pc_ready), 32'd1);
`else
    chk("addr103_imem_req", 32'(bus.imem_req), 32'd1);
    chk("addr103_imem_addr", bus.imem_addr, 32'h100);
`endif
    bus.pc_valid = 1'b0;
    tick();

    // asynchronous reset with one outstanding and one buffered
    setin(1'b1, 32'h700, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    setin(1'b1, 32'h704, 1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
    tick();
    setin(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("prerst_if_valid", 32'(bus.if_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_if_valid", 32'(bus.if_valid), 32'd0);
    setin(1'b1, 32'h900, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("in_rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("in_rst_pc_ready", 32'(bus.pc_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    setin(1'b1, 32'h800, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("post_rst_req_nognt", 32'(bus.imem_req), 32'd1);
    chk("post_rst_rdy_nognt", 32'(bus.pc_ready), 32'd0);
    bus.imem_gnt = 1'b1;
    #1;
    chk("post_rst_rdy_gnt", 32'(bus.pc_ready), 32'd1);
    chk("post_rst_if_valid", 32'(bus.if_valid), 32'd0);
    tick();
    setin(1'b1, 32'h804, 1'b1, 1'b1, 32'h88, 1'b1, 1'b0);
    #3;
    chk("post_rst_occ1_rdy", 32'(bus.pc_ready), 32'd1);
    tick();
    setin(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    #3;
    chk("post_rst_ifv_a", 32'(bus.if_valid), 32'd1);
    chk("post_rst_pc_a", bus.if_pc, 32'h800);
    chk("post_rst_instr_a", bus.if_instr, 32'h88);
    tick();
    setin(1'b0, 32'h0, 1'b0, 1'b1, 32'h99, 1'b1, 1'b0);
    #3;
    chk("post_rst_ifv_b", 32'(bus.if_valid), 32'd0);
    tick();
    setin(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    #3;
    chk("post_rst_ifv_c", 32'(bus.if_valid), 32'd1);
    chk("post_rst_pc_c", bus.if_pc, 32'h804);
    chk("post_rst_instr_c", bus.if_instr, 32'h99);
    tick();

`ifdef FETCH_MISALIGN_CHECK_EN
    setin(1'b1, 32'h6, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    chk("mis6_imem_req", 32'(bus.imem_req), 32'd0);
    chk("mis6_pc_ready", 32'(bus.pc_ready), 32'd1);
    tick();
    setin(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    #3;
    chk("mis6_if_valid", 32'(bus.if_valid), 32'd1);
    chk("mis6_if_pc", bus.if_pc, 32'h6);
    chk("mis6_if_instr", bus.if_instr, 32'h13);
    chk("mis6_if_misalign", 32'(bus.if_misalign), 32'd1);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 2: number of fetch slots, counting outstanding requests plus buffered instructions; power of 2, minimum 2.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state SHALL be on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have ports pc_valid (input, 1), pc_in (input, 32) and pc_ready (output, 1): fetch-address handshake from the program counter.
REQ-005 The module SHALL have ports imem_req (output, 1), imem_addr (output, 32) and imem_gnt (input, 1): instruction-memory request channel.
REQ-006 The module SHALL have ports imem_rvalid (input, 1) and imem_rdata (input, 32): instruction-memory response channel, in-order, no backpressure.
REQ-007 The module SHALL have ports if_valid (output, 1), if_pc (output, 32), if_instr (output, 32) and if_ready (input, 1): instruction handshake to decode.
REQ-008 The module SHALL have port flush, input, 1 bit: discard all fetched and in-flight instructions.

Function
REQ-009 The module SHALL hold occupancy count occ = outstanding requests + FIFO entries; credit SHALL be true when occ < FIFO_DEPTH.
REQ-010 The module SHALL drive imem_req = pc_valid && credit && !flush && state==RUN, combinationally.
REQ-011 The module SHALL drive imem_addr = {pc_in[31:2], 2'b00}.
REQ-012 The module SHALL drive pc_ready = imem_req && imem_gnt; a fetch is accepted only in that cycle.
REQ-013 On acceptance, the module SHALL push pc_in into an internal PC queue of FIFO_DEPTH entries and increment the outstanding count.
REQ-014 On imem_rvalid in RUN, the module SHALL pop the PC queue and write {pc, imem_rdata} into the output FIFO, with if_valid visible in the next cycle (1-cycle latency).
REQ-015 The module SHALL drive if_valid = FIFO not empty, with if_pc/if_instr taken from the FIFO head; a pop SHALL occur when if_valid && if_ready.
REQ-016 Simultaneous accept, response and pop in one cycle SHALL update occ by (+1 accept) + (-1 pop) with no loss; a response converts an outstanding slot to a FIFO slot, leaving occ unchanged.
REQ-017 The module SHALL implement FSM states RUN and DRAIN.
REQ-018 On flush in any state, the module SHALL clear the FIFO and the PC queue, and SHALL set drop_cnt = outstanding minus any response arriving in that same cycle.
REQ-019 On flush, the FSM SHALL go to DRAIN if that drop_cnt > 0, otherwise stay in RUN.
REQ-020 In DRAIN, each imem_rvalid SHALL decrement drop_cnt and its data SHALL be discarded.
REQ-021 In DRAIN, the FSM SHALL return to RUN on the cycle drop_cnt reaches 0; pc_ready SHALL be 0 throughout DRAIN.
REQ-022 During a flush cycle, if_valid SHALL still reflect pre-flush contents, but no pop SHALL be counted; the FIFO SHALL be empty in the following cycle.
REQ-023 An imem_rvalid with zero outstanding is a protocol error; it SHALL be ignored and SHALL NOT underflow any counter.

Reset
REQ-024 While rst_n=0, the module SHALL force the FIFO, PC queue, outstanding count and drop_cnt to 0, and the FSM to RUN.
REQ-025 During reset, the module SHALL hold if_valid=0, pc_ready=0 and imem_req=0.
REQ-026 Reset asserted mid-transaction SHALL abandon all in-flight state; responses arriving after reset release are not expected.
REQ-027 Reset deassertion SHALL be synchronised by the integrator; the module SHALL accept fetches on the first clock edge after release.

Configuration
REQ-028 With macro FETCH_MISALIGN_CHECK_EN defined, the module SHALL add output port if_misalign (1 bit), which SHALL be 0 under reset.
REQ-029 With FETCH_MISALIGN_CHECK_EN defined and pc_in[1:0]!=0, the module SHALL issue no memory request; it SHALL set pc_ready=credit && state==RUN && !flush && outstanding==0.
REQ-030 With FETCH_MISALIGN_CHECK_EN defined, on acceptance of a misaligned pc the module SHALL push an entry {pc_in, 32'h00000013, misalign=1} directly into the FIFO, preserving order.
REQ-031 Without FETCH_MISALIGN_CHECK_EN, the port SHALL be absent and pc_in[1:0] SHALL be ignored.

Verification
REQ-032 Scenario: pc 0x0,0x4,0x8 streamed, imem_gnt=1, rvalid 1 cycle later, if_ready=1 -> if_pc 0x0,0x4,0x8 in order, each 1 cycle after rvalid.
REQ-033 Scenario: FIFO_DEPTH=2, if_ready=0 -> exactly 2 accepts, then pc_ready=0 with pc_valid=1 until one pop.
REQ-034 Scenario: 2 outstanding, flush, then 2 rvalid with data 0xDEAD -> if_valid stays 0, FSM in DRAIN for 2 responses, pc_ready returns after the second.
REQ-035 Scenario: flush coinciding with 1 of 2 responses -> drop_cnt=1, one further response dropped.
REQ-036 Scenario: rst_n pulled low with 1 outstanding and 1 buffered -> if_valid=0 immediately (asynchronously); after release, occ=0 and pc_ready follows imem_gnt.
REQ-037 Scenario: with FETCH_MISALIGN_CHECK_EN, pc 0x6 -> no imem_req, if_misalign=1, if_instr=0x00000013, if_pc=0x6.
